std_mult_seq: RTL
=================

Name: std_mult_seq

Overview:
- Multi-cycle unsigned shift-add multiplier primitive with the Calyx go/done interface.
- Sits directly upstream of std_reg. A group drives go, waits for done, then writes out into a std_reg in the same cycle that done is high.
- Covers widths where a combinational multiplier is unavailable. Provides a true sequential primitive with a fixed, parameter-determined latency.

Parameters:
- WIDTH, 32: operand and result width in bits. Legal values are 2 to 64.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets all state immediately).
- go  input  1  start request; sampled only in IDLE.
- left  input  WIDTH  multiplicand (unsigned).
- right  input  WIDTH  multiplier (unsigned).
- out  output  WIDTH  product modulo 2^WIDTH; registered.
- done  output  1  one-cycle completion pulse; registered.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low on port reset.
- Reset values: state=IDLE, out=0, done=0, accumulator=0, shift registers=0, counter=0.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - done=0.
  - On a rising edge with go=1: latch mcand=left and mplier=right, set acc=0 and cnt=0, move to BUSY.
  - go=0 keeps the block in IDLE.
- BUSY, on each edge:
  - If mplier[0]=1 then acc <= acc + mcand (truncated to WIDTH bits).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == WIDTH-1, move to DONE and load out with the final accumulator value. That value includes the last iteration's add, computed combinationally.
  - cnt width is clog2(WIDTH).
- DONE:
  - Lasts exactly one cycle with done=1. out is valid, then the state returns to IDLE unconditionally.
  - go is ignored in DONE.
- Latency: go is first high in cycle 0 and sampled at the end of cycle 0. BUSY spans cycles 1..WIDTH. done=1 in cycle WIDTH+1 only. For WIDTH=8, done is high in cycle 9.
- Back-to-back: if go stays high through DONE, the block returns to IDLE and samples go again. The next operation starts one cycle after DONE, so the issue interval is WIDTH+2 cycles.
- Operand changes on left/right during BUSY or DONE have no effect; operands are captured only on the IDLE start edge.
- out holds the last result indefinitely, through IDLE and through a subsequent BUSY, and changes only on entry to DONE. After reset, out=0 until the first completion.
- Arithmetic: unsigned only. Overflow beyond WIDTH bits is discarded silently, with no flag.
- Zero shortcut: none. Multiplying by 0 still takes the full latency, so latency is data-independent.
- Reset asserted mid-operation (BUSY or DONE): immediately returns to IDLE with out=0 and done=0, and the in-flight result is lost. The first go after reset deassertion starts fresh.
- go during reset is ignored. After deassertion, go is sampled on the first rising edge.
- Parameter guard: under VERILATOR, $error if WIDTH < 2 or WIDTH > 64.

Test Plan:
- WIDTH=8, reset pulse, left=3, right=5, go high for one cycle (cycle 0) -> done=1 only in cycle 9, out=15 from cycle 9 onward; done=0 in cycles 1-8 and 10.
- WIDTH=8, left=255, right=255 -> out=0x01 (65025 mod 256); left=0, right=200 -> out=0 with done still in cycle 9.
- WIDTH=8, start 6*7, then set left=1, right=1 in cycle 3 -> out=42 at done; inputs are ignored after capture.
- WIDTH=8, go held high continuously with operands 2*3, then 4*5 from cycle 10 -> done in cycles 9 and 19; out=6 in cycles 9-18, then 20.
- WIDTH=8, start 9*9, drive reset=0 asynchronously mid-cycle 4 -> out=0, done=0 and state IDLE immediately. Release reset and start 2*2 -> done 9 cycles later with out=4.
- WIDTH=32, left=0x0001_0000, right=0x0001_0001 -> out=0x0001_0000 (product truncated), done in cycle 33.

Source files
------------

// File: rtl/std_mult_seq.sv
// Multi-cycle unsigned shift-add multiplier with a go/done handshake.
// Each cycle consumes one multiplier bit, so the latency is WIDTH+1 cycles no matter what the operands are.
module std_mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out,
   output logic             done
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
      $error("std_mult_seq: WIDTH must be in the range 2..64");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_sum;
   logic [CNT_W-1:0] cnt;
   logic             last_iter;

   // The final add has to land in out on the same edge that leaves BUSY, so the sum is formed combinationally.
   always_comb begin
      state_next = state;
      acc_sum    = mplier[0] ? (acc + mcand) : acc;
      last_iter  = (cnt == LAST_CNT);
      unique case (state)
         S_IDLE:  if (go) state_next = S_BUSY;
         S_BUSY:  if (last_iter) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // out is held across IDLE and BUSY, and is reloaded only on the edge that enters DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         out    <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go) begin
                  mcand  <= left;
                  mplier <= right;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            S_BUSY: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last_iter) begin
                  out  <= acc_sum;
                  done <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
